// File: rtl/process_features_mac_pipe.sv
// Pipelined signed multiply-accumulate for the primary-caps feature path.
// Multiplier stages feed a group accumulator and a single output register.
module process_features_mac_pipe #(
   parameter int DIN0_WIDTH = 32,
   parameter int DIN1_WIDTH = 32,
   parameter int PROD_WIDTH = 48,
   parameter int ACC_WIDTH  = 56,
   parameter int NUM_STAGE  = 3,
   parameter int SATURATE   = 1
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DIN0_WIDTH-1:0] din0,
   input  logic signed [DIN1_WIDTH-1:0] din1,
   input  logic                         in_first,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [ACC_WIDTH-1:0]  dout,
   output logic                         out_ovf
);

   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic adv;
   logic accept;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && !ap_rst;
   assign accept   = in_valid && in_ready;

   logic                         v1, f1, l1;
   logic signed [DIN0_WIDTH-1:0] a1;
   logic signed [DIN1_WIDTH-1:0] b1;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         v1 <= 1'b0;
         f1 <= 1'b0;
         l1 <= 1'b0;
         a1 <= '0;
         b1 <= '0;
      end else if (adv) begin
         v1 <= accept;
         if (accept) begin
            f1 <= in_first;
            l1 <= in_last;
            a1 <= din0;
            b1 <= din1;
         end
      end
   end

   // The product mod 2^PROD_WIDTH depends only on the operands mod 2^PROD_WIDTH,
   // so the multiplier is built at PROD_WIDTH rather than the full width.
   logic signed [PROD_WIDTH-1:0] a_ext, b_ext, prod1;
   assign a_ext = PROD_WIDTH'(a1);
   assign b_ext = PROD_WIDTH'(b1);
   assign prod1 = a_ext * b_ext;

   logic                         tv, tf, tl;
   logic signed [PROD_WIDTH-1:0] tp;

   generate
      if (NUM_STAGE == 1) begin : g_one
         assign tv = v1;
         assign tf = f1;
         assign tl = l1;
         assign tp = prod1;
      end else begin : g_deep
         logic [NUM_STAGE:2]           v_q, f_q, l_q;
         logic signed [PROD_WIDTH-1:0] p_q [2:NUM_STAGE];

         always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
               v_q <= '0;
               f_q <= '0;
               l_q <= '0;
               for (int i = 2; i <= NUM_STAGE; i++) p_q[i] <= '0;
            end else if (adv) begin
               v_q[2] <= v1;
               f_q[2] <= f1;
               l_q[2] <= l1;
               p_q[2] <= prod1;
               for (int i = 3; i <= NUM_STAGE; i++) begin
                  v_q[i] <= v_q[i-1];
                  f_q[i] <= f_q[i-1];
                  l_q[i] <= l_q[i-1];
                  p_q[i] <= p_q[i-1];
               end
            end
         end

         assign tv = v_q[NUM_STAGE];
         assign tf = f_q[NUM_STAGE];
         assign tl = l_q[NUM_STAGE];
         assign tp = p_q[NUM_STAGE];
      end
   endgenerate

   logic signed [ACC_WIDTH-1:0] acc_q;
   logic                        ovf_q;
   logic signed [ACC_WIDTH-1:0] base;
   logic signed [ACC_WIDTH:0]   sum;
   logic                        ovf_now;
   logic                        sticky;
   logic signed [ACC_WIDTH-1:0] result;

   always_comb begin
      base    = tf ? '0 : acc_q;
      sum     = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(tp);
      ovf_now = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
      sticky  = (tf ? 1'b0 : ovf_q) | ovf_now;
      result  = sum[ACC_WIDTH-1:0];
      if (ovf_now && (SATURATE != 0)) begin
         result = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      end
   end

   // Finished groups park in res_* for one cycle before the output register.
   logic                        res_v;
   logic signed [ACC_WIDTH-1:0] res_d;
   logic                        res_o;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
         res_v <= 1'b0;
         res_d <= '0;
         res_o <= 1'b0;
      end else if (adv) begin
         res_v <= tv && tl;
         if (tv) begin
            if (tl) begin
               res_d <= result;
               res_o <= sticky;
               acc_q <= '0;
               ovf_q <= 1'b0;
            end else begin
               acc_q <= result;
               ovf_q <= sticky;
            end
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         out_valid <= 1'b0;
         dout      <= '0;
         out_ovf   <= 1'b0;
      end else if (adv) begin
         out_valid <= res_v;
         if (res_v) begin
            dout    <= res_d;
            out_ovf <= res_o;
         end
      end
   end

endmodule

// File: doc/process_features_mac_pipe.md
Name: process_features_mac_pipe

Overview:
- Pipelined, parametrised signed multiply-accumulate unit for the primary-caps feature path.
- Successor to the single-cycle combinational signed multiplier. Adds configurable pipeline depth, valid/ready flow control, group accumulation with first/last framing, and an optional saturating accumulator with an overflow flag.
- Sits between the feature/weight streams and the capsule squash/output logic.

Parameters:
- DIN0_WIDTH, 32: signed width of operand din0.
- DIN1_WIDTH, 32: signed width of operand din1.
- PROD_WIDTH, 48: product width kept. The full signed product is truncated to its low PROD_WIDTH bits and treated as signed. Range 2..DIN0_WIDTH+DIN1_WIDTH.
- ACC_WIDTH, 56: accumulator and result width. Must be ≥ PROD_WIDTH.
- NUM_STAGE, 3: multiplier register stages, ≥ 1.
- SATURATE, 1: 1 = clamp the accumulator at signed min/max; 0 = two's-complement wrap.

Ports:
- ap_clk, in, 1: clock; all logic is rising-edge.
- ap_rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block accepts a beat this cycle.
- din0, in, DIN0_WIDTH: signed operand.
- din1, in, DIN1_WIDTH: signed operand.
- in_first, in, 1: this beat starts a new group; the accumulator restarts from 0.
- in_last, in, 1: this beat ends the group; emit the result.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- dout, out, ACC_WIDTH: signed accumulated group result.
- out_ovf, out, 1: overflow occurred in this group (saturated or wrapped).

Behaviour:
- Reset, taking effect on the first clock edge with ap_rst=1:
  - out_valid=0, dout=0, out_ovf=0.
  - All stage valid bits=0, accumulator=0, sticky overflow=0.
  - An in-flight partial group is discarded.
  - in_ready is held 0 while ap_rst=1.
- Global advance: adv = !out_valid || out_ready. in_ready = adv && !ap_rst, combinational.
  - A beat is accepted when in_valid && in_ready.
  - When adv=0 every stage, the accumulator and the output register hold.
- Multiplier pipeline:
  - Stage 1 registers the accepted operands and the first/last flags, plus a valid bit.
  - The product is din0*din1 (full signed), taken mod 2^PROD_WIDTH and reinterpreted as signed.
  - The product is ready at the end of stage NUM_STAGE. The multiply may be placed in any stage; only the total latency is fixed.
  - Bubbles (accepted cycles with no beat) carry valid=0 and do not touch the accumulator.
- Accumulate stage (a valid product p leaving stage NUM_STAGE while adv=1):
  - base = 0 if first flag set, else acc.
  - sum = base + sext(p), computed at ACC_WIDTH+1 bits.
  - Overflow when sum lies outside the signed ACC_WIDTH range.
  - SATURATE=1: result clamps to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - SATURATE=0: result keeps the low ACC_WIDTH bits.
  - Sticky ovf = (first ? 0 : ovf) | overflow this beat.
- On the last flag:
  - dout = result, out_ovf = the sticky value including this beat, out_valid=1.
  - acc and the sticky flag clear to 0, so the next group starts from 0 even if in_first is omitted.
- Without the last flag: acc = result and no output is produced.
- in_first and in_last on the same beat: single-product group; dout = sext(p), out_ovf=0.
- Output register:
  - out_valid clears on out_valid && out_ready unless a new result loads in the same cycle, in which case it stays 1 with the new data.
  - dout and out_ovf are stable while out_valid && !out_ready.
- Latency: an in_last beat accepted at edge T gives out_valid=1 after edge T+NUM_STAGE+1, with no stalls. Throughput is 1 beat/cycle when out_ready=1.
- Initiation at in_valid=0 inserts bubbles; group accumulation spans any number of bubbles.

Test Plan:
- Defaults, group (3,4)F, (-5,6), (7,-2)L, out_ready=1 → dout=-32 exactly 4 cycles after L is accepted; out_ovf=0; in_ready stays 1.
- Truncation: single beat F+L with din0=din1=0x7FFFFFFF → product low 48 bits 0xFFFF00000001 → dout=-4294967295 (sign-extended to 56 bits), out_ovf=0.
- Saturate, overrides DIN0/DIN1=8, PROD=ACC=16, SATURATE=1: beats (127,127)×3 with F on the first and L on the third → dout=32767, out_ovf=1. Same with SATURATE=0 → dout=-17149, out_ovf=1. The following group (1,1)F+L → dout=1, out_ovf=0.
- Backpressure: two back-to-back groups with results 10 and 20, out_ready=0 when the first result appears → in_ready=0, dout holds 10 for the stall duration, no beat is lost. Release out_ready → 10 then 20 emitted in order.
- Bubbles/implicit restart: (2,3)F, in_valid=0 for 5 cycles, (4,5)L → dout=26. Then (1,1) with no F, (1,1)L → dout=2.
- Reset mid-group: (100,100)F accepted, ap_rst=1 for 1 cycle, then (1,2)L with no F → out_valid stays 0 during reset; result dout=2.
